// File: rtl/vm_pkg.sv
// Shared encodings, FSM states and coin-unit helpers for the multi-channel vending controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vm_pkg;

  // Coin-in and change-out share one 2-bit code
  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_SMALL = 2'b01;
  localparam logic [1:0] COIN_BIG   = 2'b10;
  localparam logic [1:0] COIN_ILL   = 2'b11;

  // Value of the small coin in balance units
  localparam int unsigned SMALL_UNITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFUND = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  // Units the dispenser pays out next from a remaining amount: big coin
  // while it fits, otherwise a small coin, nothing once the amount is zero.
  function automatic int unsigned disp_units(input int unsigned amt, input int unsigned big);
    if (amt == 0)        return 0;
    else if (amt >= big) return big;
    else                 return SMALL_UNITS;
  endfunction

endpackage

// File: rtl/vm_change_disp.sv
// Coin dispenser: loads an amount and pays it out greedily, one big/small coin code per cycle.
// Latency: first coin appears on the edge that samples i_load; o_done is high while the last coin shows.
// Backpressure: none; the actuator takes one coin per cycle, a new i_load restarts from i_amt.
module vm_change_disp
  import vm_pkg::*;
#(
  parameter int BAL_W    = 6,
  parameter int BIG_COIN = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [BAL_W-1:0] i_amt,
  output logic [1:0]       o_coin,
  output logic             o_done
);

  logic [BAL_W-1:0] r_rem;
  logic [1:0]       r_coin;
  logic [BAL_W-1:0] w_src;
  logic [BAL_W-1:0] w_units;
  logic [1:0]       w_code;

  // Choose the amount being paid from and the coin it yields this cycle
  always_comb begin
    w_src   = i_load ? i_amt : r_rem;
    w_units = BAL_W'(disp_units(32'(w_src), BIG_COIN));
    w_code  = COIN_NONE;
    if (w_src != '0) begin
      w_code = (32'(w_src) >= BIG_COIN) ? COIN_BIG : COIN_SMALL;
    end
  end

  // Emit one coin per cycle and keep the unpaid remainder
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rem  <= '0;
      r_coin <= COIN_NONE;
    end else begin
      r_rem  <= w_src - w_units;
      r_coin <= w_code;
    end
  end

  assign o_coin = r_coin;
  // Final coin is on the output when nothing is left to pay
  assign o_done = (r_coin != COIN_NONE) && (r_rem == '0);

endmodule

// File: rtl/vm_multi.sv
// Multi-channel vending controller: coin accumulation, per-channel price/stock, refund and change payout.
// Latency: 1 cycle from sampled request to registered outputs; first change coin on the accepting edge.
// Backpressure: user requests during REFUND/CHANGE are dropped with a one-cycle err pulse.
module vm_multi
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int BAL_W      = 6,
  parameter int MAX_BAL    = 20,
  parameter int BIG_COIN   = 5,
  parameter int DEF_PRICE  = 10,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8,
  localparam int IDX_W     = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           coin_in,
  input  logic [NUM_ITEMS-1:0] item_sel,
  input  logic                 change_take,
  input  logic                 cfg_price_we,
  input  logic                 cfg_stock_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [BAL_W-1:0]     cfg_data,
  output logic [BAL_W-1:0]     money_account,
  output logic [NUM_ITEMS-1:0] beverage_out,
  output logic [1:0]           change_out,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy,
  output logic                 err
);

  state_t               r_state, w_state_nxt;
  logic [BAL_W-1:0]     r_bal, w_bal_nxt;
  logic [NUM_ITEMS-1:0] r_bev, w_bev_nxt;
  logic [NUM_ITEMS-1:0] r_sold, w_sold_nxt;
  logic                 r_busy, r_err, w_err_nxt;
  logic [BAL_W-1:0]     r_price [NUM_ITEMS];
  logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];
  logic [STOCK_W-1:0]   w_stock_nxt [NUM_ITEMS];
  logic [IDX_W-1:0]     w_sel_idx;
  logic [1:0]           w_req_cnt;
  logic                 w_sel_any, w_req_any, w_req_bad, w_vend_ok, w_vend;
  logic                 w_load, w_disp_done;
  logic [BAL_W-1:0]     w_load_amt, w_coin_units, w_refund, w_chg_dec;
  logic [BAL_W:0]       w_sum;

  // Decode the user request and precompute the arithmetic each action needs
  always_comb begin
    w_sel_any = |item_sel;
    w_req_cnt = 2'(coin_in != COIN_NONE) + 2'(w_sel_any) + 2'(change_take);
    w_req_any = (w_req_cnt != 2'd0);
    w_req_bad = (w_req_cnt > 2'd1) || (coin_in == COIN_ILL) || (w_sel_any && !$onehot(item_sel));
    w_sel_idx = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (item_sel[k]) w_sel_idx = IDX_W'(k);
    end
    w_coin_units = (coin_in == COIN_BIG) ? BAL_W'(BIG_COIN) : BAL_W'(SMALL_UNITS);
    // One extra bit so the ceiling compare cannot wrap
    w_sum     = {1'b0, r_bal} + {1'b0, w_coin_units};
    w_refund  = BAL_W'(w_sum - (BAL_W+1)'(MAX_BAL));
    w_vend_ok = (r_bal >= r_price[w_sel_idx]) && (r_stock[w_sel_idx] != '0);
    // During CHANGE the remaining payout equals the balance, so the next coin follows from it
    w_chg_dec = BAL_W'(disp_units(32'(r_bal), BIG_COIN));
  end

  // Next state, balance and pulse outputs; user requests only act in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_bal_nxt   = r_bal;
    w_bev_nxt   = '0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_load_amt  = '0;
    w_vend      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_bad) begin
          w_err_nxt = 1'b1;
        end else if (coin_in != COIN_NONE) begin
          if (w_sum <= (BAL_W+1)'(MAX_BAL)) begin
            w_bal_nxt = w_sum[BAL_W-1:0];
          end else begin
            w_bal_nxt   = BAL_W'(MAX_BAL);
            w_load      = 1'b1;
            w_load_amt  = w_refund;
            w_state_nxt = ST_REFUND;
          end
        end else if (w_sel_any) begin
          if (w_vend_ok) begin
            w_vend    = 1'b1;
            w_bev_nxt = item_sel;
            w_bal_nxt = r_bal - r_price[w_sel_idx];
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (change_take && (r_bal != '0)) begin
          w_load      = 1'b1;
          w_load_amt  = r_bal;
          w_bal_nxt   = r_bal - w_chg_dec;
          w_state_nxt = ST_CHANGE;
        end
      end
      default: begin
        w_err_nxt = w_req_any;
        if (r_state == ST_CHANGE) w_bal_nxt = r_bal - w_chg_dec;
        if (w_disp_done) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered user-facing outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_bal   <= '0;
      r_bev   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bal   <= w_bal_nxt;
      r_bev   <= w_bev_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Stock update: a config write overrides a same-cycle vend decrement
  always_comb begin
    for (int k = 0; k < NUM_ITEMS; k++) begin
      w_stock_nxt[k] = r_stock[k];
      if (w_vend && (w_sel_idx == IDX_W'(k))) w_stock_nxt[k] = r_stock[k] - STOCK_W'(1);
      if (cfg_stock_we && (cfg_idx == IDX_W'(k))) w_stock_nxt[k] = cfg_data[STOCK_W-1:0];
      w_sold_nxt[k] = (w_stock_nxt[k] == '0);
    end
  end

  // Per-channel price and stock tables plus the sold-out flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
        r_price[k] <= BAL_W'(DEF_PRICE);
        r_stock[k] <= STOCK_W'(INIT_STOCK);
      end
      r_sold <= (INIT_STOCK == 0) ? '1 : '0;
    end else begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
        if (cfg_price_we && (cfg_idx == IDX_W'(k))) r_price[k] <= cfg_data;
        r_stock[k] <= w_stock_nxt[k];
      end
      r_sold <= w_sold_nxt;
    end
  end

  vm_change_disp #(
    .BAL_W    (BAL_W),
    .BIG_COIN (BIG_COIN)
  ) u_disp (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_load),
    .i_amt  (w_load_amt),
    .o_coin (change_out),
    .o_done (w_disp_done)
  );

  assign money_account = r_bal;
  assign beverage_out  = r_bev;
  assign sold_out      = r_sold;
  assign busy          = r_busy;
  assign err           = r_err;

endmodule

// File: tb/tb_vm_multi.sv
// Bench for vm_multi: directed vector table, reset-mid-change sequence, randomized run vs a queue-based model.
module tb_vm_multi;

  localparam int N     = 4;
  localparam int BIG   = 5;
  localparam int MAXB  = 20;
  localparam int DEFP  = 10;
  localparam int INITS = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] coin_in = 2'd0;
  logic [3:0] item_sel = 4'd0;
  logic       change_take = 1'b0;
  logic       cfg_price_we = 1'b0;
  logic       cfg_stock_we = 1'b0;
  logic [1:0] cfg_idx = 2'd0;
  logic [5:0] cfg_data = 6'd0;
  logic [5:0] money_account;
  logic [3:0] beverage_out;
  logic [1:0] change_out;
  logic [3:0] sold_out;
  logic       busy;
  logic       err;

  vm_multi #(
    .NUM_ITEMS(N), .BAL_W(6), .MAX_BAL(MAXB), .BIG_COIN(BIG),
    .DEF_PRICE(DEFP), .STOCK_W(4), .INIT_STOCK(INITS)
  ) dut (
    .clk(clk), .rstn(rstn), .coin_in(coin_in), .item_sel(item_sel),
    .change_take(change_take), .cfg_price_we(cfg_price_we), .cfg_stock_we(cfg_stock_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .money_account(money_account),
    .beverage_out(beverage_out), .change_out(change_out), .sold_out(sold_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned m_bal;
  int unsigned m_price [N];
  int unsigned m_stock [N];
  logic [1:0]  m_q [$];      // coins still to be paid out, in order
  bit          m_disp;       // a payout is in progress (user requests refused)
  bit          m_chg_mode;   // payout is drawn from the balance
  logic [3:0]  e_bev;
  logic [1:0]  e_chg;
  bit          e_err;

  function automatic int unsigned units_of(input logic [1:0] c);
    return (c == 2'b10) ? BIG : 1;
  endfunction

  task automatic model_reset();
    m_bal = 0;
    for (int k = 0; k < N; k++) begin
      m_price[k] = DEFP;
      m_stock[k] = INITS;
    end
    m_q.delete();
    m_disp = 0; m_chg_mode = 0;
    e_bev = 0; e_chg = 0; e_err = 0;
  endtask

  task automatic model_pay();
    e_chg = m_q.pop_front();
    if (m_chg_mode) m_bal -= units_of(e_chg);
  endtask

  // Whole payout decided up front: as many big coins as fit, then small ones
  task automatic model_start(input int unsigned amt, input bit chg);
    m_q.delete();
    for (int i = 0; i < int'(amt / BIG); i++) m_q.push_back(2'b10);
    for (int i = 0; i < int'(amt % BIG); i++) m_q.push_back(2'b01);
    m_disp = 1; m_chg_mode = chg;
    model_pay();
  endtask

  task automatic model_step();
    int          nreq;
    int          k;
    int unsigned s;
    e_bev = 0; e_chg = 0; e_err = 0;
    nreq = int'(coin_in != 0) + int'(item_sel != 0) + int'(change_take);
    if (m_disp) begin
      if (nreq > 0) e_err = 1;
      if (m_q.size() > 0) model_pay();
      else m_disp = 0;
    end else if (nreq > 1 || coin_in == 2'b11 || (item_sel != 0 && $countones(item_sel) != 1)) begin
      e_err = 1;
    end else if (coin_in != 0) begin
      s = m_bal + units_of(coin_in);
      if (s <= MAXB) m_bal = s;
      else begin
        m_bal = MAXB;
        model_start(s - MAXB, 0);
      end
    end else if (item_sel != 0) begin
      k = 0;
      for (int j = 0; j < N; j++) if (item_sel[j]) k = j;
      if (m_bal >= m_price[k] && m_stock[k] > 0) begin
        e_bev = item_sel;
        m_bal -= m_price[k];
        m_stock[k]--;
      end else e_err = 1;
    end else if (change_take && m_bal > 0) begin
      model_start(m_bal, 1);
    end
    if (cfg_price_we) m_price[cfg_idx] = cfg_data;
    if (cfg_stock_we) m_stock[cfg_idx] = cfg_data % 16;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] sold;
    for (int k = 0; k < N; k++) sold[k] = (m_stock[k] == 0);
    check({tag, ".money"}, 32'(money_account), m_bal);
    check({tag, ".bev"},   32'(beverage_out), 32'(e_bev));
    check({tag, ".chg"},   32'(change_out), 32'(e_chg));
    check({tag, ".busy"},  32'(busy), 32'(m_disp));
    check({tag, ".err"},   32'(err), 32'(e_err));
    check({tag, ".sold"},  32'(sold_out), 32'(sold));
  endtask

  // Apply one cycle of inputs at the falling edge, advance the model at the rising edge
  task automatic drive(input logic [1:0] c, input logic [3:0] it, input logic tk,
                       input logic pwe, input logic swe, input logic [1:0] idx, input logic [5:0] d);
    @(negedge clk);
    coin_in = c; item_sel = it; change_take = tk;
    cfg_price_we = pwe; cfg_stock_we = swe; cfg_idx = idx; cfg_data = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    coin_in = 0; item_sel = 0; change_take = 0;
    cfg_price_we = 0; cfg_stock_we = 0; cfg_idx = 0; cfg_data = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int c, it, tk, pwe, swe, idx, d;
    int money, bev, chg, busy, err, sold;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(input int c, it, tk, pwe, swe, idx, d,
                              input int money, bev, chg, bsy, er, sold);
    vec_t v;
    v.c = c; v.it = it; v.tk = tk; v.pwe = pwe; v.swe = swe; v.idx = idx; v.d = d;
    v.money = money; v.bev = bev; v.chg = chg; v.busy = bsy; v.err = er; v.sold = sold;
    return v;
  endfunction

  initial begin
    logic [1:0] rc;
    logic [3:0] rit;
    logic       rtk, rpwe, rswe;
    logic [1:0] ridx;
    logic [5:0] rd;
    int         r;

    //          c it tk pw sw ix  d | money bev chg busy err sold
    tv.push_back(mk(2, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0));  // two requests at once
    tv.push_back(mk(0, 3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0));  // item_sel not one-hot
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0,  11, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  16, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  20, 0, 1, 1, 0, 0));  // overflow: refund 1 small
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0,  20, 0, 0, 0, 1, 0));  // coin while busy
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 0,  15, 0, 2, 1, 0, 0));  // change 20 = 4 big
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,  10, 0, 2, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   5, 0, 2, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0,   5, 0, 0, 0, 1, 0));  // insufficient balance
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 3,   5, 0, 0, 0, 0, 0));  // price[0]=3
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0,  16, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0,  17, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0,  18, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 4, 0, 0, 0, 0, 0,   8, 4, 0, 0, 0, 0));  // vend item 2
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 0,   3, 0, 2, 1, 0, 0));  // change 8 = big + 3 small
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0));  // stock[1]=1
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 2, 0, 0, 0, 0, 0,  10, 2, 0, 0, 0, 2));  // last unit of item 1
    tv.push_back(mk(0, 2, 0, 0, 0, 0, 0,  10, 0, 0, 0, 1, 2));  // sold out
    tv.push_back(mk(0, 0, 0, 1, 0, 3, 21, 10, 0, 0, 0, 0, 2));  // price above ceiling
    tv.push_back(mk(0, 8, 0, 0, 0, 0, 0,  10, 0, 0, 0, 1, 2));  // unbuyable
    tv.push_back(mk(0, 4, 0, 1, 0, 2, 0,   0, 4, 0, 0, 0, 2));  // vend uses old price 10
    tv.push_back(mk(0, 4, 0, 0, 0, 0, 0,   0, 4, 0, 0, 0, 2));  // free vend
    tv.push_back(mk(0, 4, 0, 0, 1, 2, 0,   0, 4, 0, 0, 0, 6));  // stock write beats vend
    tv.push_back(mk(0, 4, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 6));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 6));

    // Reset state
    model_reset();
    idle_inputs();
    #12;
    check("rst.money", 32'(money_account), 0);
    check("rst.bev",   32'(beverage_out), 0);
    check("rst.chg",   32'(change_out), 0);
    check("rst.busy",  32'(busy), 0);
    check("rst.err",   32'(err), 0);
    check("rst.sold",  32'(sold_out), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed table
    for (int i = 0; i < tv.size(); i++) begin
      drive(2'(tv[i].c), 4'(tv[i].it), 1'(tv[i].tk), 1'(tv[i].pwe), 1'(tv[i].swe),
            2'(tv[i].idx), 6'(tv[i].d));
      check($sformatf("vec%0d.money", i), 32'(money_account), 32'(tv[i].money));
      check($sformatf("vec%0d.bev", i),   32'(beverage_out), 32'(tv[i].bev));
      check($sformatf("vec%0d.chg", i),   32'(change_out), 32'(tv[i].chg));
      check($sformatf("vec%0d.busy", i),  32'(busy), 32'(tv[i].busy));
      check($sformatf("vec%0d.err", i),   32'(err), 32'(tv[i].err));
      check($sformatf("vec%0d.sold", i),  32'(sold_out), 32'(tv[i].sold));
    end

    // Reset in the middle of a change payout
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("midrst.pre_money", 32'(money_account), 5);
    check("midrst.pre_chg",   32'(change_out), 2);
    check("midrst.pre_busy",  32'(busy), 1);
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    #1;
    check("midrst.chg",   32'(change_out), 0);
    check("midrst.money", 32'(money_account), 0);
    check("midrst.busy",  32'(busy), 0);
    check("midrst.sold",  32'(sold_out), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    // Prices back to default: item 3 (was 21) buyable at 10, item 2 (was 0) costs 10 again
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0, 0);
    check("postrst.money", 32'(money_account), 10);
    drive(0, 8, 0, 0, 0, 0, 0);
    check("postrst.bev3",  32'(beverage_out), 8);
    check("postrst.money2", 32'(money_account), 0);
    drive(0, 4, 0, 0, 0, 0, 0);
    check("postrst.err2",  32'(err), 1);
    check("postrst.bev2",  32'(beverage_out), 0);
    check_model("postrst");

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      rc = 0; rit = 0; rtk = 0;
      if (r < 40) begin
        rc = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(1, 2));
      end else if (r < 65) begin
        rit = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'(1 << $urandom_range(0, 3));
      end else if (r < 72) begin
        rtk = 1;
      end else if (r < 78) begin
        rc  = 2'($urandom_range(0, 2));
        rit = 4'($urandom_range(0, 15));
        rtk = 1'($urandom_range(0, 1));
      end
      rpwe = ($urandom_range(0, 15) == 0);
      rswe = ($urandom_range(0, 11) == 0);
      ridx = 2'($urandom_range(0, 3));
      rd   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
      drive(rc, rit, rtk, rpwe, rswe, ridx, rd);
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
